// File: rtl/nw_vc_output_port_pkg.sv
// Shared types for the router output-port VC tracker.
// Holds the VC state encoding and the credit-width helper.
package nw_vc_output_port_pkg;

    typedef struct packed {
        logic        head;
        logic        tail;
        logic [31:0] data;
    } flit_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic nearly_full;
        logic nearly_empty;
    } fifov_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } vc_out_state_t;

    function automatic int clogb2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    localparam int default_buffer_length = 8;
    localparam int default_credit_w = clogb2(default_buffer_length + 1);

    typedef logic [default_credit_w-1:0] credit_t;

endpackage

// File: rtl/nw_vc_output_port_if.sv
// Grant, flit-departure and credit-return signals for one output port,
// plus the per-VC status it reports back to the allocators.
interface nw_vc_output_port_if
    import nw_vc_output_port_pkg::*;
#(
    parameter int num_vcs       = 4,
    parameter int buffer_length = 8
);
    localparam int credit_w = clogb2(buffer_length + 1);

    logic [num_vcs-1:0]               vc_alloc_valid;
    logic                             flit_valid;
    logic [num_vcs-1:0]               flit_vc;
    logic                             flit_tail;
    logic                             credit_valid;
    logic [num_vcs-1:0]               credit_vc;
    logic [num_vcs-1:0]               vc_free;
    logic [num_vcs-1:0]               vc_can_send;
    logic [num_vcs-1:0][credit_w-1:0] credits;
    logic                             error;

    modport master (
        output vc_alloc_valid, flit_valid, flit_vc, flit_tail,
        output credit_valid, credit_vc,
        input  vc_free, vc_can_send, credits, error
    );

    modport slave (
        input  vc_alloc_valid, flit_valid, flit_vc, flit_tail,
        input  credit_valid, credit_vc,
        output vc_free, vc_can_send, credits, error
    );

endinterface

// File: rtl/nw_vc_credit_fsm.sv
// One downstream VC: credit counter plus IDLE/ACTIVE/DRAIN state.
// err is a single-cycle pulse; the top level makes it sticky.
module nw_vc_credit_fsm
    import nw_vc_output_port_pkg::*;
#(
    parameter int buffer_length    = 8,
    parameter bit release_on_empty = 1'b1,
    parameter int credit_w         = clogb2(buffer_length + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send,
    input  logic                tail,
    input  logic                alloc,
    input  logic                cred,
    output logic                free,
    output logic                can_send,
    output logic [credit_w-1:0] count,
    output logic                err
);

    localparam logic [credit_w-1:0] full = credit_w'(buffer_length);

    vc_out_state_t       state;
    vc_out_state_t       state_nxt;
    logic [credit_w-1:0] count_nxt;
    logic                cnt_err;
    logic                fsm_err;
    vc_out_state_t       tail_state;

    always_comb begin
        count_nxt = count;
        cnt_err   = 1'b0;
        if (send && !cred) begin
            if (count == '0) cnt_err = 1'b1;
            else             count_nxt = count - 1'b1;
        end else if (cred && !send) begin
            if (count == full) cnt_err = 1'b1;
            else               count_nxt = count + 1'b1;
        end
    end

    // Hold the VC until every outstanding credit is back, if configured
    assign tail_state = (release_on_empty && count_nxt != full) ? DRAIN : IDLE;

    always_comb begin
        state_nxt = state;
        fsm_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (alloc) begin
                    if (send && tail) state_nxt = tail_state;
                    else              state_nxt = ACTIVE;
                end else if (send) begin
                    fsm_err = 1'b1;
                end
            end
            ACTIVE: begin
                fsm_err = alloc;
                if (send && tail) state_nxt = tail_state;
            end
            DRAIN: begin
                fsm_err = alloc | send;
                if (count_nxt == full) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= full;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign free     = (state == IDLE);
    assign can_send = (count != '0);
    assign err      = cnt_err | fsm_err;

endmodule

// File: rtl/nw_vc_output_port.sv
// Upstream tracker for one router output port: per-VC credits and state,
// with one-hot screening of events and a sticky protocol error flag.
module nw_vc_output_port
    import nw_vc_output_port_pkg::*;
#(
    parameter int num_vcs          = 4,
    parameter int buffer_length    = 8,
    parameter bit release_on_empty = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    nw_vc_output_port_if.slave vc_if
);

    localparam int credit_w = clogb2(buffer_length + 1);

    logic               flit_ok;
    logic               credit_ok;
    logic               bad_vc;
    logic [num_vcs-1:0] send;
    logic [num_vcs-1:0] cred;
    logic [num_vcs-1:0] err;

    // A malformed VC select is dropped entirely rather than guessed at
    assign flit_ok   = vc_if.flit_valid & $onehot(vc_if.flit_vc);
    assign credit_ok = vc_if.credit_valid & $onehot(vc_if.credit_vc);
    assign bad_vc    = (vc_if.flit_valid & ~flit_ok)
                     | (vc_if.credit_valid & ~credit_ok);

    assign send = {num_vcs{flit_ok}} & vc_if.flit_vc;
    assign cred = {num_vcs{credit_ok}} & vc_if.credit_vc;

    for (genvar i = 0; i < num_vcs; i++) begin : g_vc
        nw_vc_credit_fsm #(
            .buffer_length    (buffer_length),
            .release_on_empty (release_on_empty),
            .credit_w         (credit_w)
        ) u_fsm (
            .clk      (clk),
            .rst_n    (rst_n),
            .send     (send[i]),
            .tail     (vc_if.flit_tail),
            .alloc    (vc_if.vc_alloc_valid[i]),
            .cred     (cred[i]),
            .free     (vc_if.vc_free[i]),
            .can_send (vc_if.vc_can_send[i]),
            .count    (vc_if.credits[i]),
            .err      (err[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vc_if.error <= 1'b0;
        else        vc_if.error <= vc_if.error | bad_vc | (|err);
    end

endmodule

// File: tb/tb_nw_vc_output_port.sv
// Randomized and directed check of nw_vc_output_port against a
// reference model; one instance releases on empty, one on tail.
module tb_nw_vc_output_port;

    localparam int NV = 4;
    localparam int BL = 4;
    localparam int S_IDLE = 0;
    localparam int S_ACT  = 1;
    localparam int S_DRN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int total = 0;
    int bad = 0;

    nw_vc_output_port_if #(.num_vcs(NV), .buffer_length(BL)) ifc_a ();
    nw_vc_output_port_if #(.num_vcs(NV), .buffer_length(BL)) ifc_b ();

    nw_vc_output_port #(
        .num_vcs(NV), .buffer_length(BL), .release_on_empty(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .vc_if(ifc_a.slave)
    );

    nw_vc_output_port #(
        .num_vcs(NV), .buffer_length(BL), .release_on_empty(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .vc_if(ifc_b.slave)
    );

    // model state, index 0 = release_on_empty=1, 1 = release_on_empty=0
    int m_state [2][NV];
    int m_cnt   [2][NV];
    bit m_err   [2];

    logic [NV-1:0] s_alloc, s_fvc, s_cvc;
    logic          s_fv, s_ft, s_cv, s_rst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit oh(input logic [NV-1:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit rel;
            bit e;
            rel = (k == 0);
            if (!s_rst) begin
                for (int i = 0; i < NV; i++) begin
                    m_state[k][i] = S_IDLE;
                    m_cnt[k][i] = BL;
                end
                m_err[k] = 0;
                continue;
            end
            e = (s_fv && !oh(s_fvc)) || (s_cv && !oh(s_cvc));
            for (int i = 0; i < NV; i++) begin
                bit s, c, a;
                int n, tail_st;
                s = s_fv && oh(s_fvc) && s_fvc[i];
                c = s_cv && oh(s_cvc) && s_cvc[i];
                a = s_alloc[i];
                n = m_cnt[k][i] - int'(s) + int'(c);
                if (n < 0)  begin n = 0;  e = 1; end
                if (n > BL) begin n = BL; e = 1; end
                tail_st = (rel && n < BL) ? S_DRN : S_IDLE;
                case (m_state[k][i])
                    S_IDLE: begin
                        if (a) m_state[k][i] = (s && s_ft) ? tail_st : S_ACT;
                        else if (s) e = 1;
                    end
                    S_ACT: begin
                        if (a) e = 1;
                        if (s && s_ft) m_state[k][i] = tail_st;
                    end
                    default: begin
                        if (a || s) e = 1;
                        if (n == BL) m_state[k][i] = S_IDLE;
                    end
                endcase
                m_cnt[k][i] = n;
            end
            m_err[k] = m_err[k] | e;
        end
    endtask

    task automatic compare_all();
        logic [NV-1:0] ef, ec;
        logic [3*NV-1:0] ecr;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NV; i++) begin
                ef[i] = (m_state[k][i] == S_IDLE);
                ec[i] = (m_cnt[k][i] != 0);
                ecr[3*i +: 3] = 3'(m_cnt[k][i]);
            end
            if (k == 0) begin
                chk("a_free", 32'(ifc_a.vc_free), 32'(ef));
                chk("a_cansend", 32'(ifc_a.vc_can_send), 32'(ec));
                chk("a_credits", 32'(ifc_a.credits), 32'(ecr));
                chk("a_error", 32'(ifc_a.error), 32'(m_err[0]));
            end else begin
                chk("b_free", 32'(ifc_b.vc_free), 32'(ef));
                chk("b_cansend", 32'(ifc_b.vc_can_send), 32'(ec));
                chk("b_credits", 32'(ifc_b.credits), 32'(ecr));
                chk("b_error", 32'(ifc_b.error), 32'(m_err[1]));
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [NV-1:0] al,
                       input logic fv, input logic [NV-1:0] fvc,
                       input logic ft, input logic cv,
                       input logic [NV-1:0] cvc);
        s_rst = r; s_alloc = al; s_fv = fv; s_fvc = fvc;
        s_ft = ft; s_cv = cv; s_cvc = cvc;
        rst_n = r;
        ifc_a.vc_alloc_valid = al; ifc_b.vc_alloc_valid = al;
        ifc_a.flit_valid = fv;     ifc_b.flit_valid = fv;
        ifc_a.flit_vc = fvc;       ifc_b.flit_vc = fvc;
        ifc_a.flit_tail = ft;      ifc_b.flit_tail = ft;
        ifc_a.credit_valid = cv;   ifc_b.credit_valid = cv;
        ifc_a.credit_vc = cvc;     ifc_b.credit_vc = cvc;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic do_reset();
        cyc(0, '0, 0, '0, 0, 0, '0);
    endtask

    function automatic logic [NV-1:0] pick_vc(input int want);
        int i;
        for (int t = 0; t < 4; t++) begin
            i = $urandom_range(0, NV - 1);
            if (want == 0 && m_state[0][i] == S_ACT) return NV'(1) << i;
            if (want == 1 && m_cnt[0][i] < BL) return NV'(1) << i;
        end
        if ($urandom_range(0, 9) == 0) return NV'($urandom_range(0, 15));
        return NV'(1) << $urandom_range(0, NV - 1);
    endfunction

    initial begin
        rst_n = 0;
        do_reset();
        do_reset();
        chk("rst_free", 32'(ifc_a.vc_free), 32'hf);
        chk("rst_cansend", 32'(ifc_a.vc_can_send), 32'hf);
        chk("rst_credits", 32'(ifc_a.credits), 32'h924);
        chk("rst_error", 32'(ifc_a.error), 32'h0);

        // drain VC1's credits, then overrun
        cyc(1, 4'b0010, 0, '0, 0, 0, '0);
        for (int j = 0; j < 4; j++) begin
            cyc(1, '0, 1, 4'b0010, 0, 0, '0);
            chk("vc1_count", 32'(ifc_a.credits[1]), 32'(3 - j));
        end
        chk("vc1_cansend", 32'(ifc_a.vc_can_send[1]), 32'h0);
        cyc(1, '0, 1, 4'b0010, 0, 0, '0);
        chk("vc1_over_err", 32'(ifc_a.error), 32'h1);
        chk("vc1_over_cnt", 32'(ifc_a.credits[1]), 32'h0);
        do_reset();

        // single-flit packet on VC2 with alloc in the same cycle
        cyc(1, 4'b0100, 1, 4'b0100, 1, 0, '0);
        chk("vc2_drain", 32'(ifc_a.vc_free[2]), 32'h0);
        chk("vc2_cnt", 32'(ifc_a.credits[2]), 32'h3);
        chk("vc2_b_free", 32'(ifc_b.vc_free[2]), 32'h1);
        idle();
        cyc(1, '0, 0, '0, 0, 1, 4'b0100);
        chk("vc2_release", 32'(ifc_a.vc_free[2]), 32'h1);
        chk("vc2_err", 32'(ifc_a.error), 32'h0);

        // simultaneous send and credit, then credit overflow on VC0
        cyc(1, 4'b0001, 1, 4'b0001, 0, 0, '0);
        cyc(1, '0, 1, 4'b0001, 0, 0, '0);
        cyc(1, '0, 1, 4'b0001, 0, 1, 4'b0001);
        chk("vc0_hold", 32'(ifc_a.credits[0]), 32'h2);
        cyc(1, '0, 0, '0, 0, 1, 4'b0001);
        cyc(1, '0, 0, '0, 0, 1, 4'b0001);
        chk("vc0_noerr", 32'(ifc_a.error), 32'h0);
        cyc(1, '0, 0, '0, 0, 1, 4'b0001);
        chk("vc0_ovf_err", 32'(ifc_a.error), 32'h1);
        chk("vc0_ovf_cnt", 32'(ifc_a.credits[0]), 32'h4);
        do_reset();

        // release on tail: VC3 reusable before credits return
        cyc(1, 4'b1000, 0, '0, 0, 0, '0);
        cyc(1, '0, 1, 4'b1000, 0, 0, '0);
        cyc(1, '0, 1, 4'b1000, 1, 0, '0);
        chk("vc3_b_free", 32'(ifc_b.vc_free[3]), 32'h1);
        chk("vc3_b_cnt", 32'(ifc_b.credits[3]), 32'h2);
        chk("vc3_a_free", 32'(ifc_a.vc_free[3]), 32'h0);
        cyc(1, 4'b1000, 0, '0, 0, 0, '0);
        chk("vc3_b_realloc", 32'(ifc_b.vc_free[3]), 32'h0);
        chk("vc3_b_err", 32'(ifc_b.error), 32'h0);
        do_reset();

        // reset mid-packet, alloc during reset ignored
        cyc(1, 4'b0010, 0, '0, 0, 0, '0);
        for (int j = 0; j < 3; j++) cyc(1, '0, 1, 4'b0010, 0, 0, '0);
        chk("mid_cnt", 32'(ifc_a.credits[1]), 32'h1);
        cyc(0, 4'b0100, 0, '0, 0, 0, '0);
        chk("mid_free", 32'(ifc_a.vc_free), 32'hf);
        chk("mid_credits", 32'(ifc_a.credits), 32'h924);
        chk("mid_error", 32'(ifc_a.error), 32'h0);
        idle();
        chk("mid_vc2", 32'(ifc_a.vc_free[2]), 32'h1);

        for (int n = 0; n < 800; n++) begin
            logic [NV-1:0] al;
            for (int i = 0; i < NV; i++) al[i] = ($urandom_range(0, 7) == 0);
            cyc($urandom_range(0, 59) != 0, al,
                1'($urandom_range(0, 1)), pick_vc(0),
                ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), pick_vc(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nw_vc_output_port.md
Name: nw_vc_output_port

Overview:
- Upstream-side tracker for one router output port; the counterpart of the downstream router's input VC buffers.
- Holds, per downstream VC, the free/allocated state and a credit count that mirrors free slots in the downstream VC buffer.
- Feeds vc_free to the VC allocator and vc_can_send to the switch allocator.
- Updated by departing flits, new VC grants, and credits returned from downstream.

Parameters:
- num_vcs, 4, number of downstream virtual channels.
- buffer_length, 8, depth of each downstream VC buffer; this is the initial and maximum credit count.
- release_on_empty, 1, 1 = a VC becomes free only after its tail is sent and all credits have returned; 0 = a VC is freed as soon as its tail is sent.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- vc_alloc_valid  in  num_vcs  bit i = downstream VC i granted to some input this cycle.
- flit_valid  in  1  a flit leaves this output port this cycle.
- flit_vc  in  num_vcs  one-hot downstream VC of the departing flit.
- flit_tail  in  1  the departing flit is a tail (single-flit packets have head=tail=1).
- credit_valid  in  1  a credit is returned from downstream this cycle.
- credit_vc  in  num_vcs  one-hot VC of the returned credit.
- vc_free  out  num_vcs  VC i is IDLE and allocatable.
- vc_can_send  out  num_vcs  VC i credit count > 0.
- credits  out  num_vcs x clogb2(buffer_length+1)  per-VC credit count.
- error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n=0 at posedge clk): all VCs go to IDLE, credits[i]=buffer_length, error=0. Outputs after reset: vc_free=all 1s, vc_can_send=all 1s. Reset mid-packet discards all state.
- Let send_i = flit_valid & flit_vc[i], and cred_i = credit_valid & credit_vc[i].
- Credit counter, next value:
  - send_i only: count-1.
  - cred_i only: count+1.
  - send_i and cred_i together: unchanged.
  - send_i with count==0 (no cred_i): counter holds 0, error set.
  - cred_i with count==buffer_length (no send_i): counter holds, error set.
- Per-VC FSM, states IDLE, ACTIVE, DRAIN:
  - IDLE + vc_alloc_valid[i]: go to ACTIVE.
  - Allocation and send in the same cycle is legal (unpipelined VC/switch allocation). If that send is a tail, use the tail rule below instead of going to ACTIVE.
  - IDLE + send_i without allocation: error set, state stays IDLE, counter still updates.
  - ACTIVE + send_i with flit_tail=1: go to DRAIN if release_on_empty=1 and the next count is below buffer_length; otherwise go to IDLE.
  - DRAIN: go to IDLE in the cycle the next count equals buffer_length. A send_i in DRAIN sets error.
  - vc_alloc_valid[i] in ACTIVE or DRAIN: error set, grant ignored.
- Latency: every effect becomes visible on the outputs on the cycle after the triggering edge.
  - vc_free and vc_can_send are decoded from registered state and counts only; there is no combinational path from any input.
  - Consequently a VC released at edge N is allocatable from cycle N+1.
- Multiple bits of vc_alloc_valid may be set in one cycle; each VC is handled independently.
- Non-one-hot flit_vc or credit_vc while its valid is high: error set, and that event is applied to no VC.
- error is cleared only by reset.

Decomposition:
- Shared package, alongside the existing flit_t and fifov_flags_t:
  - vc_out_state_t enum {IDLE, ACTIVE, DRAIN};
  - the credit-width type, derived from clogb2(buffer_length+1) in NW_functions.
- Sub-module nw_vc_credit_fsm: one VC's counter plus FSM, with ports send, tail, alloc, cred, free, can_send, count, err. It is instantiated num_vcs times in a generate loop.
- Top level does the one-hot checking and ORs the per-VC err outputs into the sticky error register.

Test Plan (num_vcs=4, buffer_length=4, release_on_empty=1 unless stated):
- Reset then idle: vc_free=4'b1111, vc_can_send=4'b1111, credits all 4, error=0.
- Alloc VC1, then 4 body flits on VC1 with no credits returned: credits[1] goes 3,2,1,0 and vc_can_send[1]=0. A 5th send sets error=1 and credits[1] stays 0.
- Alloc VC2 and a single-flit (tail) send on VC2 in the same cycle: next cycle vc_free[2]=0 (DRAIN), credits[2]=3. The credit for VC2 returns 2 cycles later; the following cycle vc_free[2]=1.
- On VC0, a send and a credit in the same cycle at credits=2: stays 2. A credit at credits=4: error=1, count holds 4.
- release_on_empty=0: alloc VC3, then tail send with credits[3]=3. Next cycle vc_free[3]=1 while credits[3]=2, and VC3 can be reallocated immediately.
- Reset asserted while VC1 is ACTIVE with credits[1]=1: next cycle vc_free=4'b1111, credits[1]=4, error=0. An alloc of VC2 in the same cycle as rst_n=0 is ignored.
